spi_xfer_ctrl: RTL

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl_if.sv | 41 ++++
 rtl/spi_xfer_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if
// Groups the host-side request/result signals and the byte-engine handshake
// of the SPI transaction controller into one bundle.
//
// Signals:
//   sndRec   host -> ctrl   transaction request (level)
//   TXDATA   host -> ctrl   bytes to send, MSB byte first
//   DOUT     ctrl -> host   received bytes, first byte in the MSBs
//   DONE     ctrl -> host   one-cycle completion pulse
//   ERR      ctrl -> host   sticky timeout flag
//   SS       ctrl -> slave  slave select, active low
//   getByte  ctrl -> engine byte transfer request
//   sndData  ctrl -> engine byte currently offered
//   BUSY     engine -> ctrl byte engine busy
//   RxData   engine -> ctrl last byte received
//
// Modports: master = the controller, slave = host/engine side.
interface spi_xfer_ctrl_if #(
    parameter int NBYTES = 5
);
    logic                  sndRec;
    logic [NBYTES*8-1:0]   TXDATA;
    logic [NBYTES*8-1:0]   DOUT;
    logic                  DONE;
    logic                  ERR;
    logic                  SS;
    logic                  getByte;
    logic [7:0]            sndData;
    logic                  BUSY;
    logic [7:0]            RxData;

    modport master (
        input  sndRec, TXDATA, BUSY, RxData,
        output DOUT, DONE, ERR, SS, getByte, sndData
    );

    modport slave (
        output sndRec, TXDATA, BUSY, RxData,
        input  DOUT, DONE, ERR, SS, getByte, sndData
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
// Sequences an NBYTES-long SPI transaction on top of a byte-level SPI
// engine: offers each byte of a captured TXDATA word (MSB byte first),
// collects the echoed bytes into DOUT, optionally idles GAP_CYC cycles
// between bytes with SS still low, and aborts to a sticky ERR if the engine
// stalls for TIMEOUT cycles. All state changes on the falling edge of CLK.
//
// Ports:
//   CLK  block clock (falling-edge active)
//   RST  asynchronous, active-high reset
//   bus  spi_xfer_ctrl_if.master (request, result and byte-engine handshake)
module spi_xfer_ctrl #(
    parameter int NBYTES  = 5,
    parameter int GAP_CYC = 0,
    parameter int TIMEOUT = 0
) (
    input  logic            CLK,
    input  logic            RST,
    spi_xfer_ctrl_if.master bus
);

    localparam int W  = NBYTES * 8;
    localparam int CW = $clog2(NBYTES + 1);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] BYTE_LAST = CW'(NBYTES);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   byte_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [W-1:0]    shadow;
    logic [W-1:0]    shift_reg;
    logic [W-1:0]    dout;
    logic            err;
    logic            was_done;
    logic            armed;

    logic            start;
    logic            timeout_hit;
    logic            gap_hit;
    logic [W-1:0]    shift_next;
    logic [CW-1:0]   byte_idx;
    logic [W-1:0]    byte_word;
    logic [7:0]      byte_sel;

    logic            ss;
    logic            get_byte;
    logic [7:0]      snd_data;

    // A request is only honoured once sndRec has been seen low in IDLE, so a
    // request held high across completion cannot retrigger.
    assign start       = (state == ST_IDLE) && bus.sndRec && armed;
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == TO_LAST);
    assign gap_hit     = (gap_cnt == GAP_LAST);
    assign shift_next  = (shift_reg << 8) | W'(bus.RxData);

    // The counter has already advanced once INIT is left, so every state
    // after INIT points at the byte just handed to the engine.
    assign byte_idx  = (state == ST_INIT) ? byte_cnt : byte_cnt - 1'b1;
    assign byte_word = shadow << {byte_idx, 3'b000};
    assign byte_sel  = byte_word[W-1 -: 8];

    // Next-state and output decode.
    always_comb begin
        state_next = state;
        ss         = 1'b1;
        get_byte   = 1'b0;
        snd_data   = 8'h00;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_INIT;
                end
            end

            ST_INIT: begin
                ss       = 1'b0;
                get_byte = 1'b1;
                snd_data = byte_sel;
                if (bus.BUSY) begin
                    state_next = ST_WAIT;
                end else if (timeout_hit) begin
                    state_next = ST_FAIL;
                end
            end

            ST_WAIT: begin
                ss       = 1'b0;
                snd_data = byte_sel;
                if (!bus.BUSY) begin
                    state_next = ST_CHECK;
                end else if (timeout_hit) begin
                    state_next = ST_FAIL;
                end
            end

            ST_CHECK: begin
                ss       = 1'b0;
                snd_data = byte_sel;
                if (byte_cnt == BYTE_LAST) begin
                    state_next = ST_DONE;
                end else if (GAP_CYC > 0) begin
                    state_next = ST_GAP;
                end else begin
                    state_next = ST_INIT;
                end
            end

            ST_GAP: begin
                ss       = 1'b0;
                snd_data = byte_sel;
                if (gap_hit) begin
                    state_next = ST_INIT;
                end
            end

            ST_DONE: begin
                if (!bus.sndRec) begin
                    state_next = ST_IDLE;
                end
            end

            ST_FAIL: begin
                if (!bus.sndRec) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and datapath.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            shadow    <= '0;
            shift_reg <= '0;
            dout      <= '0;
            err       <= 1'b0;
            was_done  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state    <= state_next;
            was_done <= (state == ST_DONE);

            if (state == ST_IDLE) begin
                armed <= !bus.sndRec;
            end

            case (state)
                ST_IDLE: begin
                    byte_cnt  <= '0;
                    shift_reg <= '0;
                    if (start) begin
                        shadow <= bus.TXDATA;
                        err    <= 1'b0;
                    end
                end

                ST_INIT: begin
                    if (bus.BUSY) begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    shift_reg <= shift_next;
                    // Load DOUT on the way into DONE so it is already valid
                    // while the DONE pulse is high.
                    if (byte_cnt == BYTE_LAST) begin
                        dout <= shift_next;
                    end
                end

                ST_DONE: begin
                    dout <= shift_reg;
                end

                default: begin
                end
            endcase

            if (state_next == ST_FAIL) begin
                err <= 1'b1;
            end

            if ((state_next == ST_INIT || state_next == ST_WAIT) && state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == ST_INIT && !bus.BUSY) || (state == ST_WAIT && bus.BUSY)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state_next == ST_GAP && state != ST_GAP) begin
                gap_cnt <= '0;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    assign bus.SS      = ss;
    assign bus.getByte = get_byte;
    assign bus.sndData = snd_data;
    assign bus.DOUT    = dout;
    assign bus.DONE    = (state == ST_DONE) && !was_done;
    assign bus.ERR     = err;

endmodule
